// File: rtl/bp_be_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : bp_be_issue_queue
//  Description : In-order issue FIFO between the FE instruction stream and
//                the BE checker. Each instruction is pre-decoded on enqueue;
//                the stored decode of the head entry is presented as issue
//                status (isd_*). The head pops when the checker grants
//                dispatch, and flush_i drops every entry.
//  Ports       : clk_i, reset_i (async, active high)
//                fe_v_i / fe_ready_o / fe_pc_i / fe_instr_i  - enqueue side
//                flush_i                                     - drop all
//                chk_dispatch_v_i                            - pop head
//                isd_v_o, isd_pc_o, isd_instr_o, isd_rs*_addr_o,
//                isd_{i,f}rs*_v_o, isd_{mem,fence,csr,long}_v_o - head status
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_be_issue_queue #(
    parameter int vaddr_width_p = 39,
    parameter int fifo_els_p    = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     fe_v_i,
    output logic                     fe_ready_o,
    input  logic [vaddr_width_p-1:0] fe_pc_i,
    input  logic [31:0]              fe_instr_i,

    input  logic                     flush_i,
    input  logic                     chk_dispatch_v_i,

    output logic                     isd_v_o,
    output logic [vaddr_width_p-1:0] isd_pc_o,
    output logic [31:0]              isd_instr_o,
    output logic [4:0]               isd_rs1_addr_o,
    output logic [4:0]               isd_rs2_addr_o,
    output logic [4:0]               isd_rs3_addr_o,
    output logic                     isd_irs1_v_o,
    output logic                     isd_irs2_v_o,
    output logic                     isd_frs1_v_o,
    output logic                     isd_frs2_v_o,
    output logic                     isd_frs3_v_o,
    output logic                     isd_mem_v_o,
    output logic                     isd_fence_v_o,
    output logic                     isd_csr_v_o,
    output logic                     isd_long_v_o
);

    localparam int c_ptr_w = $clog2(fifo_els_p);
    localparam int c_cnt_w = c_ptr_w + 1;

    typedef struct packed {
        logic irs1_v;
        logic irs2_v;
        logic frs1_v;
        logic frs2_v;
        logic frs3_v;
        logic mem_v;
        logic fence_v;
        logic csr_v;
        logic long_v;
    } decode_t;

    // Storage (no reset needed: contents are only observed while valid)
    logic [vaddr_width_p-1:0] r_pc_mem    [fifo_els_p];
    logic [31:0]              r_instr_mem [fifo_els_p];
    decode_t                  r_dec_mem   [fifo_els_p];

    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_cnt_w-1:0] r_count;

    logic    w_full;
    logic    w_empty;
    logic    w_enq;
    logic    w_deq;
    decode_t w_dec;
    decode_t w_head_dec;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [4:0] w_funct5;
    logic [6:0] w_funct7;

    assign w_opcode = fe_instr_i[6:0];
    assign w_funct3 = fe_instr_i[14:12];
    assign w_funct5 = fe_instr_i[31:27];
    assign w_funct7 = fe_instr_i[31:25];

    // Ready depends on the registered count only, so a grant in a full
    // cycle cannot open the enqueue side until the following cycle.
    assign w_full  = (r_count == c_cnt_w'(fifo_els_p));
    assign w_empty = (r_count == '0);
    assign w_enq   = fe_v_i & ~w_full & ~flush_i;
    assign w_deq   = chk_dispatch_v_i & ~w_empty & ~flush_i;

    // ------------------------------------------------------------------
    // Pre-decode of the incoming instruction
    // ------------------------------------------------------------------
    always_comb begin
        w_dec = '0;
        case (w_opcode)
            7'b0110011, 7'b0111011: begin
                w_dec.irs1_v = 1'b1;
                w_dec.irs2_v = 1'b1;
                // M-extension divide/remainder
                w_dec.long_v = (w_funct7 == 7'b0000001) & w_funct3[2];
            end
            7'b0010011, 7'b0011011, 7'b1100111: w_dec.irs1_v = 1'b1;
            7'b0000011: begin
                w_dec.irs1_v = 1'b1;
                w_dec.mem_v  = 1'b1;
            end
            7'b0100011, 7'b0101111: begin
                w_dec.irs1_v = 1'b1;
                w_dec.irs2_v = 1'b1;
                w_dec.mem_v  = 1'b1;
            end
            7'b1100011: begin
                w_dec.irs1_v = 1'b1;
                w_dec.irs2_v = 1'b1;
            end
            7'b0000111: begin
                w_dec.irs1_v = 1'b1;
                w_dec.mem_v  = 1'b1;
            end
            7'b0100111: begin
                w_dec.irs1_v = 1'b1;
                w_dec.frs2_v = 1'b1;
                w_dec.mem_v  = 1'b1;
            end
            7'b0001111: w_dec.fence_v = 1'b1;
            7'b1110011: begin
                w_dec.csr_v  = (w_funct3 != 3'd0);
                // register-source CSR forms; immediate forms read no register
                w_dec.irs1_v = (w_funct3 == 3'd1) | (w_funct3 == 3'd2)
                             | (w_funct3 == 3'd3);
            end
            7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: begin
                w_dec.frs1_v = 1'b1;
                w_dec.frs2_v = 1'b1;
                w_dec.frs3_v = 1'b1;
            end
            7'b1010011: begin
                // int->fp moves/converts read the integer file only
                if ((w_funct5 == 5'b11010) || (w_funct5 == 5'b11110)) begin
                    w_dec.irs1_v = 1'b1;
                end else begin
                    w_dec.frs1_v = 1'b1;
                    w_dec.frs2_v = (w_funct5 <= 5'b00101) | (w_funct5 == 5'b10100);
                    w_dec.long_v = (w_funct5 == 5'b00011) | (w_funct5 == 5'b01011);
                end
            end
            default: w_dec = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_pc_mem[r_wptr]    <= fe_pc_i;
            r_instr_mem[r_wptr] <= fe_instr_i;
            r_dec_mem[r_wptr]   <= w_dec;
        end
    end

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_wptr <= r_wptr + c_ptr_w'(1);
            if (w_deq) r_rptr <= r_rptr + c_ptr_w'(1);
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Head status; class bits are qualified by head valid
    // ------------------------------------------------------------------
    assign w_head_dec     = r_dec_mem[r_rptr];
    assign fe_ready_o     = ~w_full;
    assign isd_v_o        = ~w_empty;
    assign isd_pc_o       = r_pc_mem[r_rptr];
    assign isd_instr_o    = r_instr_mem[r_rptr];
    assign isd_rs1_addr_o = isd_instr_o[19:15];
    assign isd_rs2_addr_o = isd_instr_o[24:20];
    assign isd_rs3_addr_o = isd_instr_o[31:27];
    assign isd_irs1_v_o   = ~w_empty & w_head_dec.irs1_v;
    assign isd_irs2_v_o   = ~w_empty & w_head_dec.irs2_v;
    assign isd_frs1_v_o   = ~w_empty & w_head_dec.frs1_v;
    assign isd_frs2_v_o   = ~w_empty & w_head_dec.frs2_v;
    assign isd_frs3_v_o   = ~w_empty & w_head_dec.frs3_v;
    assign isd_mem_v_o    = ~w_empty & w_head_dec.mem_v;
    assign isd_fence_v_o  = ~w_empty & w_head_dec.fence_v;
    assign isd_csr_v_o    = ~w_empty & w_head_dec.csr_v;
    assign isd_long_v_o   = ~w_empty & w_head_dec.long_v;

endmodule
`default_nettype wire

// File: tb/tb_bp_be_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bp_be_issue_queue
//  Description : Self-checking bench for bp_be_issue_queue. A queue-based
//                reference model tracks the FIFO contents and a rule-based
//                decoder supplies the expected hazard-class bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_be_issue_queue;

    localparam int VW    = 39;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          fe_v;
    logic          fe_ready;
    logic [VW-1:0] fe_pc;
    logic [31:0]   fe_instr;
    logic          flush;
    logic          grant;
    logic          isd_v;
    logic [VW-1:0] isd_pc;
    logic [31:0]   isd_instr;
    logic [4:0]    rs1, rs2, rs3;
    logic          irs1_v, irs2_v, frs1_v, frs2_v, frs3_v;
    logic          mem_v, fence_v, csr_v, long_v;
    logic [8:0]    obs_cls;

    assign obs_cls = {irs1_v, irs2_v, frs1_v, frs2_v, frs3_v,
                      mem_v, fence_v, csr_v, long_v};

    bp_be_issue_queue #(.vaddr_width_p(VW), .fifo_els_p(DEPTH)) dut (
        .clk_i            (clk),
        .reset_i          (rst),
        .fe_v_i           (fe_v),
        .fe_ready_o       (fe_ready),
        .fe_pc_i          (fe_pc),
        .fe_instr_i       (fe_instr),
        .flush_i          (flush),
        .chk_dispatch_v_i (grant),
        .isd_v_o          (isd_v),
        .isd_pc_o         (isd_pc),
        .isd_instr_o      (isd_instr),
        .isd_rs1_addr_o   (rs1),
        .isd_rs2_addr_o   (rs2),
        .isd_rs3_addr_o   (rs3),
        .isd_irs1_v_o     (irs1_v),
        .isd_irs2_v_o     (irs2_v),
        .isd_frs1_v_o     (frs1_v),
        .isd_frs2_v_o     (frs2_v),
        .isd_frs3_v_o     (frs3_v),
        .isd_mem_v_o      (mem_v),
        .isd_fence_v_o    (fence_v),
        .isd_csr_v_o      (csr_v),
        .isd_long_v_o     (long_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [VW-1:0] pc;
        logic [31:0]   instr;
    } ent_t;
    ent_t mq[$];

    // Expected class vector {irs1,irs2,frs1,frs2,frs3,mem,fence,csr,long}
    function automatic logic [8:0] ref_decode(logic [31:0] ins);
        int  op = int'(ins[6:0]);
        int  f3 = int'(ins[14:12]);
        int  f5 = int'(ins[31:27]);
        int  f7 = int'(ins[31:25]);
        bit  i1 = 0, i2 = 0, fp1 = 0, fp2 = 0, fp3 = 0;
        bit  mm = 0, fe = 0, cs = 0, lg = 0;
        if (op == 'h33 || op == 'h3B) begin
            i1 = 1; i2 = 1; lg = (f7 == 1) && (f3 >= 4);
        end else if (op == 'h13 || op == 'h1B || op == 'h67) begin
            i1 = 1;
        end else if (op == 'h03 || op == 'h07) begin
            i1 = 1; mm = 1;
        end else if (op == 'h23 || op == 'h2F) begin
            i1 = 1; i2 = 1; mm = 1;
        end else if (op == 'h63) begin
            i1 = 1; i2 = 1;
        end else if (op == 'h27) begin
            i1 = 1; fp2 = 1; mm = 1;
        end else if (op == 'h0F) begin
            fe = 1;
        end else if (op == 'h73) begin
            cs = (f3 != 0); i1 = (f3 >= 1 && f3 <= 3);
        end else if (op == 'h43 || op == 'h47 || op == 'h4B || op == 'h4F) begin
            fp1 = 1; fp2 = 1; fp3 = 1;
        end else if (op == 'h53) begin
            if (f5 == 26 || f5 == 30) i1 = 1;
            else begin
                fp1 = 1;
                fp2 = (f5 <= 5) || (f5 == 20);
                lg  = (f5 == 3) || (f5 == 11);
            end
        end
        return {i1, i2, fp1, fp2, fp3, mm, fe, cs, lg};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  tab [18] = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h67, 7'h03,
                                  7'h23, 7'h63, 7'h2F, 7'h07, 7'h27, 7'h0F,
                                  7'h73, 7'h43, 7'h47, 7'h4B, 7'h4F, 7'h53};
        logic [31:0] r   = $urandom();
        int          idx = int'($urandom_range(0, 18));
        if (idx < 18) r[6:0] = tab[idx];
        if ((r[6:0] == 7'h33 || r[6:0] == 7'h3B) && $urandom_range(0, 1) == 1)
            r[31:25] = 7'b0000001;
        return r;
    endfunction

    task automatic drive(bit v, logic [VW-1:0] pc, logic [31:0] ins, bit g, bit f);
        fe_v = v; fe_pc = pc; fe_instr = ins; grant = g; flush = f;
    endtask

    // One clock: model follows the enqueue/dequeue/flush rules at the edge.
    task automatic tick(output bit enq_ok, output bit deq_ok);
        bit e, d;
        @(posedge clk);
        e = fe_v && !flush && (mq.size() < DEPTH);
        d = grant && !flush && (mq.size() > 0);
        if (flush) mq.delete();
        else begin
            if (d) mq.delete(0);
            if (e) mq.push_back('{fe_pc, fe_instr});
        end
        enq_ok = e; deq_ok = d;
        @(negedge clk);
    endtask

    task automatic step();
        bit e, d;
        tick(e, d);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, '0, '0, 0, 0);
        @(negedge clk);
        n_tests++; if (isd_v !== 1'b0) begin n_fail++; $display("FAIL reset_isd_v: got %b expected 0", isd_v); end
        n_tests++; if (fe_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", fe_ready); end
        n_tests++; if (obs_cls !== 9'b0) begin n_fail++; $display("FAIL reset_cls: got %b expected 0", obs_cls); end
        rst = 1'b0;
        mq.delete();
        @(negedge clk);
    endtask

    task automatic test_basic();
        drive(1, 39'h80000000, 32'h002081B3, 0, 0);
        step();
        drive(0, '0, '0, 0, 0);
        n_tests++; if (isd_v !== 1'b1) begin n_fail++; $display("FAIL basic_v: got %b expected 1", isd_v); end
        n_tests++; if (rs1 !== 5'd1) begin n_fail++; $display("FAIL basic_rs1: got %0d expected 1", rs1); end
        n_tests++; if (rs2 !== 5'd2) begin n_fail++; $display("FAIL basic_rs2: got %0d expected 2", rs2); end
        n_tests++; if (obs_cls !== 9'b110000000) begin n_fail++; $display("FAIL basic_cls: got %b expected 110000000", obs_cls); end
        n_tests++; if (isd_pc !== 39'h80000000) begin n_fail++; $display("FAIL basic_pc: got %h expected 80000000", isd_pc); end
        drive(0, '0, '0, 1, 0);
        step();
        n_tests++; if (isd_v !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %b expected 0", isd_v); end
    endtask

    task automatic test_decode();
        logic [31:0] ins;
        drive(1, 39'h100, 32'h0220C1B3, 0, 0);
        step();
        n_tests++; if (long_v !== 1'b1) begin n_fail++; $display("FAIL div_long: got %b expected 1", long_v); end
        n_tests++; if (obs_cls !== 9'b110000001) begin n_fail++; $display("FAIL div_cls: got %b expected 110000001", obs_cls); end
        // pop the div while pushing fmadd.s
        drive(1, 39'h104, 32'h18208243, 1, 0);
        step();
        n_tests++; if (obs_cls !== 9'b001110000) begin n_fail++; $display("FAIL fma_cls: got %b expected 001110000", obs_cls); end
        n_tests++; if (rs3 !== 5'd3) begin n_fail++; $display("FAIL fma_rs3: got %0d expected 3", rs3); end
        drive(0, '0, '0, 1, 0);
        step();
        for (int i = 0; i < 40; i++) begin
            ins = rand_instr();
            drive(1, 39'h200 + VW'(4 * i), ins, 0, 0);
            step();
            n_tests++; if (obs_cls !== ref_decode(ins)) begin n_fail++; $display("FAIL rand_cls: instr %h got %b expected %b", ins, obs_cls, ref_decode(ins)); end
            n_tests++; if ({rs1, rs2, rs3} !== {ins[19:15], ins[24:20], ins[31:27]}) begin n_fail++; $display("FAIL rand_rs: instr %h got %h expected %h", ins, {rs1, rs2, rs3}, {ins[19:15], ins[24:20], ins[31:27]}); end
            drive(0, '0, '0, 1, 0);
            step();
        end
    endtask

    task automatic test_full();
        logic [VW-1:0] exp_pc [4];
        for (int i = 0; i < 4; i++) begin
            drive(1, 39'h1000 + VW'(4 * i), rand_instr(), 0, 0);
            step();
            n_tests++; if (fe_ready !== (i < 3)) begin n_fail++; $display("FAIL full_ready%0d: got %b expected %b", i, fe_ready, (i < 3)); end
        end
        // fifth held by FE while full
        drive(1, 39'h1010, 32'h00000013, 0, 0);
        step();
        n_tests++; if (fe_ready !== 1'b0) begin n_fail++; $display("FAIL full_held_ready: got %b expected 0", fe_ready); end
        n_tests++; if (isd_pc !== 39'h1000) begin n_fail++; $display("FAIL full_head: got %h expected 1000", isd_pc); end
        // grant while full: space appears next cycle, fifth not taken this edge
        drive(1, 39'h1010, 32'h00000013, 1, 0);
        step();
        n_tests++; if (fe_ready !== 1'b1) begin n_fail++; $display("FAIL full_free_ready: got %b expected 1", fe_ready); end
        n_tests++; if (isd_pc !== 39'h1004) begin n_fail++; $display("FAIL full_head2: got %h expected 1004", isd_pc); end
        drive(1, 39'h1010, 32'h00000013, 0, 0);
        step();
        n_tests++; if (fe_ready !== 1'b0) begin n_fail++; $display("FAIL full_refill: got %b expected 0", fe_ready); end
        exp_pc = '{39'h1004, 39'h1008, 39'h100C, 39'h1010};
        for (int k = 0; k < 4; k++) begin
            n_tests++; if (isd_pc !== exp_pc[k]) begin n_fail++; $display("FAIL full_order%0d: got %h expected %h", k, isd_pc, exp_pc[k]); end
            drive(0, '0, '0, 1, 0);
            step();
        end
        n_tests++; if (isd_v !== 1'b0) begin n_fail++; $display("FAIL full_empty: got %b expected 0", isd_v); end
    endtask

    task automatic test_back_to_back();
        drive(1, 39'h2000, rand_instr(), 0, 0); step();
        drive(1, 39'h2004, rand_instr(), 0, 0); step();
        drive(1, 39'h2008, rand_instr(), 1, 0); step();
        drive(0, '0, '0, 1, 0);
        n_tests++; if (isd_pc !== 39'h2004) begin n_fail++; $display("FAIL b2b_head0: got %h expected 2004", isd_pc); end
        step();
        n_tests++; if (isd_pc !== 39'h2008) begin n_fail++; $display("FAIL b2b_head1: got %h expected 2008", isd_pc); end
        step();
        n_tests++; if (isd_v !== 1'b0) begin n_fail++; $display("FAIL b2b_count: got %b expected 0", isd_v); end
        drive(0, '0, '0, 0, 0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1, 39'h3000 + VW'(4 * i), rand_instr(), 0, 0);
            step();
        end
        drive(1, 39'h3FFC, 32'h00000013, 1, 1);
        step();
        drive(0, '0, '0, 0, 0);
        n_tests++; if (isd_v !== 1'b0) begin n_fail++; $display("FAIL flush_v: got %b expected 0", isd_v); end
        n_tests++; if (fe_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b expected 1", fe_ready); end
        step();
        n_tests++; if (isd_v !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: got %b expected 0", isd_v); end
        drive(1, 39'h3100, 32'h00000013, 0, 0);
        step();
        drive(0, '0, '0, 1, 0);
        n_tests++; if (isd_pc !== 39'h3100) begin n_fail++; $display("FAIL flush_new: got %h expected 3100", isd_pc); end
        step();
        n_tests++; if (isd_v !== 1'b0) begin n_fail++; $display("FAIL flush_drain: got %b expected 0", isd_v); end
        drive(0, '0, '0, 0, 0);
    endtask

    task automatic test_stream();
        logic [31:0] ins [10];
        int  next_i = 0;
        int  popped = 0;
        int  cyc    = 0;
        bit  e, d;
        for (int i = 0; i < 10; i++) ins[i] = rand_instr();
        while (popped < 10 && cyc < 300) begin
            if (next_i < 10 && $urandom_range(0, 3) != 0)
                drive(1, 39'h40000000 + VW'(4 * next_i), ins[next_i], 0, 0);
            else
                drive(0, '0, '0, 0, 0);
            grant = ($urandom_range(0, 2) != 0);
            tick(e, d);
            if (e) next_i++;
            if (d) popped++;
            cyc++;
            n_tests++; if (isd_v !== (mq.size() != 0)) begin n_fail++; $display("FAIL stream_v: got %b expected %b", isd_v, (mq.size() != 0)); end
            n_tests++; if (fe_ready !== (mq.size() < DEPTH)) begin n_fail++; $display("FAIL stream_ready: got %b expected %b", fe_ready, (mq.size() < DEPTH)); end
            if (mq.size() != 0) begin
                n_tests++; if (isd_pc !== mq[0].pc) begin n_fail++; $display("FAIL stream_pc: got %h expected %h", isd_pc, mq[0].pc); end
                n_tests++; if (isd_instr !== mq[0].instr) begin n_fail++; $display("FAIL stream_instr: got %h expected %h", isd_instr, mq[0].instr); end
                n_tests++; if (obs_cls !== ref_decode(mq[0].instr)) begin n_fail++; $display("FAIL stream_cls: got %b expected %b", obs_cls, ref_decode(mq[0].instr)); end
            end
        end
        n_tests++; if (popped !== 10) begin n_fail++; $display("FAIL stream_done: popped %0d expected 10 within budget", popped); end

        // reset in the middle of a fresh stream
        drive(1, 39'h50000000, rand_instr(), 0, 0); step();
        drive(1, 39'h50000004, rand_instr(), 0, 0); step();
        n_tests++; if (isd_v !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got %b expected 1", isd_v); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if (isd_v !== 1'b0) begin n_fail++; $display("FAIL midrst_v: got %b expected 0", isd_v); end
        n_tests++; if (fe_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", fe_ready); end
        n_tests++; if (obs_cls !== 9'b0) begin n_fail++; $display("FAIL midrst_cls: got %b expected 0", obs_cls); end
        mq.delete();
        drive(0, '0, '0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (isd_v !== 1'b0) begin n_fail++; $display("FAIL postrst_v: got %b expected 0", isd_v); end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, '0, '0, 0, 0);
        test_reset();
        test_basic();
        test_decode();
        test_full();
        test_back_to_back();
        test_flush();
        test_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
